// File: rtl/tile_pixel_buffer.sv
// tile_pixel_buffer
//   Tile color buffer between the rasterizer and the framebuffer writer.
//   Pixels arriving on pix_* are written into a TILE_W x TILE_H color RAM,
//   addressed by the integer part of their fixed-point coordinates taken
//   modulo the tile size. A flush handshake streams the whole tile out in
//   row-major order on out_*, then the block goes back to accepting pixels.
//
//   Ports
//     clk, rst          clock, asynchronous active-high reset
//     pix_vld/pix_rdy   pixel stream handshake; pix_color, pix_x, pix_y payload
//     flush_vld/rdy     flush request handshake; flush_clear sampled with it
//     out_vld/out_rdy   output word handshake; out_color, out_lx, out_ly payload
//     out_last          marks the final word of a flush
//     flush_done        one-cycle pulse after the out_last handshake
//
//   Build option
//     TILE_PIXEL_BUFFER_CLEAR_ON_FLUSH_EN: when defined, every entry is
//     rewritten with the latched flush_clear color right after it is read,
//     so the tile starts clean after each flush. When undefined, a flush is
//     read-only and flush_clear is ignored.
module tile_pixel_buffer #(
    parameter int COORD_W = 32,
    parameter int FRAC_W  = 16,
    parameter int COLOR_W = 24,
    parameter int TILE_W  = 16,
    parameter int TILE_H  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_vld,
    output logic                      pix_rdy,
    input  logic [COLOR_W-1:0]        pix_color,
    input  logic [COORD_W-1:0]        pix_x,
    input  logic [COORD_W-1:0]        pix_y,
    input  logic                      flush_vld,
    output logic                      flush_rdy,
    input  logic [COLOR_W-1:0]        flush_clear,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [COLOR_W-1:0]        out_color,
    output logic [$clog2(TILE_W)-1:0] out_lx,
    output logic [$clog2(TILE_H)-1:0] out_ly,
    output logic                      out_last,
    output logic                      flush_done
);

    localparam int LX_W  = $clog2(TILE_W);
    localparam int LY_W  = $clog2(TILE_H);
    localparam int AW    = LX_W + LY_W;
    localparam int DEPTH = TILE_W * TILE_H;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_ACCEPT,
        S_FLUSH
    } state_t;

    state_t state, state_d;

    // Shared index: clear pointer in INIT, read-issue pointer in FLUSH.
    logic [AW-1:0] idx;
    logic          issued_all;

    // Read pipeline: one read in flight at most per cycle, one-cycle latency.
    logic               issue;
    logic               rd_vld;
    logic [AW-1:0]      rd_idx;
    logic [COLOR_W-1:0] rd_data;

    // Two-entry output skid FIFO.
    logic [1:0][COLOR_W-1:0] sk_color;
    logic [1:0][AW-1:0]      sk_idx;
    logic                    sk_wp, sk_rp;
    logic [1:0]              sk_cnt;
    logic                    pop;

    // RAM write port.
    logic               mem_we;
    logic [AW-1:0]      mem_wa;
    logic [COLOR_W-1:0] mem_wd;
    logic [COLOR_W-1:0] mem [DEPTH];

    logic [AW-1:0] pix_addr;
    logic          pix_hs;
    logic          flush_hs;

`ifdef TILE_PIXEL_BUFFER_CLEAR_ON_FLUSH_EN
    logic [COLOR_W-1:0] clr_color;
`else
    logic unused_flush_clear;
    assign unused_flush_clear = ^flush_clear;
`endif

    // Only the integer bits inside the tile select the entry; the rest of
    // the coordinate is intentionally dropped so addressing wraps.
    logic unused_coord_bits;
    assign unused_coord_bits = ^{pix_x, pix_y};

    assign pix_addr = {pix_y[FRAC_W +: LY_W], pix_x[FRAC_W +: LX_W]};

    assign out_vld   = (sk_cnt != 2'd0);
    assign out_color = sk_color[sk_rp];
    assign out_lx    = sk_idx[sk_rp][LX_W-1:0];
    assign out_ly    = sk_idx[sk_rp][AW-1:LX_W];
    assign out_last  = out_vld && (sk_idx[sk_rp] == LAST_IDX);
    assign pop       = out_vld && out_rdy;

    assign pix_hs   = pix_vld && pix_rdy;
    assign flush_hs = flush_vld && flush_rdy;

    always_comb begin
        state_d   = state;
        pix_rdy   = 1'b0;
        flush_rdy = 1'b0;
        issue     = 1'b0;
        mem_we    = 1'b0;
        mem_wa    = idx;
        mem_wd    = '0;
        case (state)
            S_INIT: begin
                mem_we = 1'b1;
                if (idx == LAST_IDX) state_d = S_ACCEPT;
            end
            S_ACCEPT: begin
                pix_rdy   = 1'b1;
                // A pending pixel always wins over a simultaneous flush.
                flush_rdy = !pix_vld;
                if (pix_hs) begin
                    mem_we = 1'b1;
                    mem_wa = pix_addr;
                    mem_wd = pix_color;
                end
                if (flush_hs) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                // Issue only if the word is guaranteed a skid slot: entries
                // held after this cycle's pop plus the read already in flight.
                issue = !issued_all &&
                        (({1'b0, sk_cnt} + {2'b0, rd_vld}) < (3'd2 + {2'b0, pop}));
`ifdef TILE_PIXEL_BUFFER_CLEAR_ON_FLUSH_EN
                // Entry read last cycle is now safe to overwrite.
                if (rd_vld) begin
                    mem_we = 1'b1;
                    mem_wa = rd_idx;
                    mem_wd = clr_color;
                end
`endif
                if (pop && out_last) state_d = S_ACCEPT;
            end
            default: state_d = S_INIT;
        endcase
    end

    // Color RAM: no reset, registered read.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        if (issue)  rd_data     <= mem[idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_INIT;
            idx        <= '0;
            issued_all <= 1'b0;
            rd_vld     <= 1'b0;
            rd_idx     <= '0;
            sk_color   <= '0;
            sk_idx     <= '0;
            sk_wp      <= 1'b0;
            sk_rp      <= 1'b0;
            sk_cnt     <= 2'd0;
            flush_done <= 1'b0;
`ifdef TILE_PIXEL_BUFFER_CLEAR_ON_FLUSH_EN
            clr_color  <= '0;
`endif
        end else begin
            state      <= state_d;
            flush_done <= pop && out_last;
            rd_vld     <= issue;

            case (state)
                S_INIT: idx <= idx + 1'b1;   // wraps to 0 on the way out
                S_ACCEPT: begin
                    if (flush_hs) begin
                        idx        <= '0;
                        issued_all <= 1'b0;
`ifdef TILE_PIXEL_BUFFER_CLEAR_ON_FLUSH_EN
                        clr_color  <= flush_clear;
`endif
                    end
                end
                S_FLUSH: begin
                    if (issue) begin
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) issued_all <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (issue) rd_idx <= idx;

            if (rd_vld) begin
                sk_color[sk_wp] <= rd_data;
                sk_idx[sk_wp]   <= rd_idx;
                sk_wp           <= ~sk_wp;
            end
            if (pop) sk_rp <= ~sk_rp;
            sk_cnt <= sk_cnt + {1'b0, rd_vld} - {1'b0, pop};
        end
    end

endmodule
